// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, word type, schedule and round helper functions.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } sched_state_e;

  localparam word_t SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Rotate right; n is always a constant in [1,31] at call sites.
  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t sigma0_small(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sigma1_small(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Round-function helpers used by the compression engine.
  function automatic word_t sigma0_big(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t sigma1_big(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_wk_scheduler.sv
// SHA-256 message scheduler: takes one 512-bit block and streams W[t]+K[t] for t=0..63,
// expanding W[16..63] from a 16-word sliding window as each word is consumed.
module sha256_wk_scheduler
  import sha256_pkg::*;
#(
  parameter int unsigned K_ADD = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic [31:0]  wk,
  output logic         wk_valid,
  input  logic         wk_ready,
  output logic [5:0]   round,
  output logic         last,
  output logic         busy
);

  localparam bit AddK = (K_ADD != 0);

  sched_state_e state_q, state_d;
  logic [5:0]   round_q, round_d;
  word_t        win_q [16];
  word_t        win_d [16];
  word_t        w_new;

  // Next-state logic: block load in idle, window shift and round advance on accept.
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    win_d     = win_q;
    blk_ready = 1'b0;
    wk_valid  = 1'b0;
    busy      = 1'b0;
    // Expansion past t=47 feeds words that are never emitted; left ungated for simplicity.
    w_new     = sigma1_small(win_q[14]) + win_q[9] + sigma0_small(win_q[1]) + win_q[0];
    case (state_q)
      StIdle: begin
        blk_ready = 1'b1;
        if (blk_valid) begin
          for (int i = 0; i < 16; i++) begin
            win_d[i] = blk_data[511 - 32*i -: 32];
          end
          round_d = 6'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        wk_valid = 1'b1;
        busy     = 1'b1;
        if (wk_ready) begin
          for (int i = 0; i < 15; i++) begin
            win_d[i] = win_q[i+1];
          end
          win_d[15] = w_new;
          if (round_q == 6'd63) begin
            round_d = 6'd0;
            state_d = StIdle;
          end else begin
            round_d = round_q + 6'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Round word is a pure function of registered state, so wk_ready never reaches wk.
  always_comb begin
    wk = '0;
    if (state_q == StRun) begin
      wk = AddK ? (win_q[0] + SHA256_K[round_q]) : win_q[0];
    end
  end

  assign round = round_q;
  assign last  = (state_q == StRun) && (round_q == 6'd63);

  // State, round counter and window registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      round_q <= '0;
      win_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      win_q   <= win_d;
    end
  end

endmodule

// File: tb/tb_sha256_wk_scheduler.sv
// Self-checking bench for sha256_wk_scheduler: known "abc" vectors, a FIPS-style schedule
// reference model, backpressure, ignored blk_valid during RUN, mid-block reset, random blocks.
module tb_sha256_wk_scheduler;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         blk_valid;
  logic [511:0] blk_data;
  logic         wk_ready;

  logic         blk_ready, wk_valid, last, busy;
  logic [31:0]  wk;
  logic [5:0]   round;

  logic         blk_ready_r, wk_valid_r, last_r, busy_r;
  logic [31:0]  wk_r;
  logic [5:0]   round_r;

  always #5 clk = ~clk;

  sha256_wk_scheduler #(.K_ADD(1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .blk_valid(blk_valid),
    .blk_ready(blk_ready),
    .blk_data (blk_data),
    .wk       (wk),
    .wk_valid (wk_valid),
    .wk_ready (wk_ready),
    .round    (round),
    .last     (last),
    .busy     (busy)
  );

  // Raw-W variant driven by the same stimulus.
  sha256_wk_scheduler #(.K_ADD(0)) dut_raw (
    .clk      (clk),
    .reset_n  (reset_n),
    .blk_valid(blk_valid),
    .blk_ready(blk_ready_r),
    .blk_data (blk_data),
    .wk       (wk_r),
    .wk_valid (wk_valid_r),
    .wk_ready (wk_ready),
    .round    (round_r),
    .last     (last_r),
    .busy     (busy_r)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] kt [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0] exp_w [64];
  logic [31:0] cap_k [64];
  logic [31:0] cap_raw [64];

  typedef struct {
    int          rnd;
    logic [31:0] wk_k;
    logic [31:0] wk_raw;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Full 64-entry message schedule computed directly from the recurrence.
  task automatic build_model(input logic [511:0] d);
    for (int i = 0; i < 16; i++) exp_w[i] = d[511 - 32*i -: 32];
    for (int t = 16; t < 64; t++) begin
      exp_w[t] = ss1(exp_w[t-2]) + exp_w[t-7] + ss0(exp_w[t-15]) + exp_w[t-16];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " blk_ready"}, 32'(blk_ready), 32'd1);
    chk({tag, " wk_valid"}, 32'(wk_valid), 32'd0);
    chk({tag, " wk"}, wk, 32'd0);
    chk({tag, " wk_raw"}, wk_r, 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " last"}, 32'(last), 32'd0);
  endtask

  // Offer block d, then consume all 64 words, optionally stalling 5 cycles at stall_at,
  // resetting at abort_at, or holding blk_valid high with other data throughout.
  task automatic run_block(input logic [511:0] d, input int stall_at, input int abort_at,
                           input bit hold_valid, input logic [511:0] noise);
    build_model(d);
    chk("load blk_ready", 32'(blk_ready), 32'd1);
    blk_valid = 1'b1;
    blk_data  = d;
    wk_ready  = 1'b1;
    step;
    if (hold_valid) blk_data = noise;
    else blk_valid = 1'b0;
    for (int t = 0; t < 64; t++) begin
      cap_k[t]   = wk;
      cap_raw[t] = wk_r;
      chk($sformatf("wk r%0d", t), wk, exp_w[t] + kt[t]);
      chk($sformatf("wk_raw r%0d", t), wk_r, exp_w[t]);
      chk($sformatf("round r%0d", t), 32'(round), t);
      chk($sformatf("wk_valid r%0d", t), 32'(wk_valid), 32'd1);
      chk($sformatf("last r%0d", t), 32'(last), (t == 63) ? 32'd1 : 32'd0);
      chk($sformatf("blk_ready r%0d", t), 32'(blk_ready), 32'd0);
      chk($sformatf("busy r%0d", t), 32'(busy), 32'd1);
      if (t == stall_at) begin
        wk_ready = 1'b0;
        repeat (5) begin
          step;
          chk($sformatf("stall wk r%0d", t), wk, exp_w[t] + kt[t]);
          chk($sformatf("stall round r%0d", t), 32'(round), t);
          chk($sformatf("stall wk_valid r%0d", t), 32'(wk_valid), 32'd1);
        end
        wk_ready = 1'b1;
      end
      if (t == abort_at) begin
        reset_n   = 1'b0;
        blk_valid = 1'b0;
        step;
        reset_n = 1'b1;
        check_idle("abort");
        chk("abort round", 32'(round), 32'd0);
        return;
      end
      step;
    end
    check_idle("after last");
  endtask

  logic [511:0] abc_blk;
  logic [511:0] rnd_blk;
  logic [511:0] noise_blk;

  initial begin
    abc_blk = {32'h61626380, 448'h0, 32'h00000018};
    vecs[0] = '{0,  32'ha3ec9318, 32'h61626380};
    vecs[1] = '{1,  32'h71374491, 32'h00000000};
    vecs[2] = '{15, 32'hc19bf18c, 32'h00000018};
    vecs[3] = '{16, 32'h45fdcd41, 32'h61626380};
    vecs[4] = '{17, 32'hefcd4786, 32'h000f0000};

    reset_n   = 1'b0;
    blk_valid = 1'b0;
    blk_data  = '0;
    wk_ready  = 1'b0;
    step;
    step;
    reset_n = 1'b1;
    check_idle("reset");
    chk("reset round", 32'(round), 32'd0);

    // Reset pulse while idle leaves it idle.
    reset_n = 1'b0;
    step;
    reset_n = 1'b1;
    step;
    check_idle("idle reset");

    // "abc" block with a 5-cycle stall at round 16, then known-answer table.
    run_block(abc_blk, 16, -1, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("abc wk r%0d", vecs[i].rnd), cap_k[vecs[i].rnd], vecs[i].wk_k);
      chk($sformatf("abc raw r%0d", vecs[i].rnd), cap_raw[vecs[i].rnd], vecs[i].wk_raw);
    end

    // blk_valid held high with other data during RUN: ignored, then taken after last.
    for (int j = 0; j < 16; j++) noise_blk[511 - 32*j -: 32] = $urandom;
    run_block(abc_blk, -1, -1, 1'b1, noise_blk);
    run_block(noise_blk, -1, -1, 1'b0, '0);

    // Reset mid-block at round 30, then a fresh block restarts at round 0.
    for (int j = 0; j < 16; j++) rnd_blk[511 - 32*j -: 32] = $urandom;
    run_block(rnd_blk, -1, 30, 1'b0, '0);
    step;
    check_idle("post abort");
    run_block(abc_blk, -1, -1, 1'b0, '0);

    // Random blocks, random stall point, random idle gaps.
    for (int b = 0; b < 4; b++) begin
      repeat ($urandom_range(0, 3)) begin
        step;
        check_idle("gap");
      end
      for (int j = 0; j < 16; j++) rnd_blk[511 - 32*j -: 32] = $urandom;
      run_block(rnd_blk, int'($urandom_range(0, 63)), -1, 1'b0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
